// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the two-port block-transfer memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    DONE
  } arb_state_t;

  // Word-index width for a block: IDX_W = $clog2(BLOCK_WORDS).
  function automatic int idx_w(input int block_words);
    return $clog2(block_words);
  endfunction

  // Byte-offset width inside a block: OFFSET_W = IDX_W + 2.
  function automatic int offset_w(input int block_words);
    return idx_w(block_words) + 2;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant selection; exists only when MEM_ARB_RR_EN is defined.
`ifdef MEM_ARB_RR_EN
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_port,
  output logic       sel
);

  logic last;

  always_ff @(posedge clk) begin
    if (!rst)     last <= 1'b1;
    else if (upd) last <= upd_port;
  end

  // On a tie the port not served last wins; otherwise the lone requester.
  always_comb begin
    sel = 1'b0;
    if (req == 2'b11) sel = ~last;
    else              sel = req[1] & ~req[0];
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Block-transfer arbiter sharing one fixed-latency memory port between two requesters.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = 32,
  parameter int MEM_LAT     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     req,
  input  logic [1:0]                     req_we,
  input  logic [1:0][31:0]               req_addr,
  input  logic [1:0][31:0]               req_wdata,
  output logic [1:0]                     gnt,
  output logic [1:0]                     rvalid,
  output logic [1:0]                     wack,
  output logic [1:0]                     done,
  output logic [31:0]                    rdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
  output logic                           mem_ren,
  output logic                           mem_wen,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_din,
  input  logic [31:0]                    mem_dout
);

  localparam int IDX_W    = idx_w(BLOCK_WORDS);
  localparam int OFFSET_W = offset_w(BLOCK_WORDS);
  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_WORDS - 1);

  arb_state_t              state;
  logic                    win;
  logic [31-OFFSET_W:0]    base;
  logic [CNT_W-1:0]        cnt;
  logic                    sel;
  logic [1:0]              sel_oh;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[0][OFFSET_W-1:0], req_addr[1][OFFSET_W-1:0]};

`ifdef MEM_ARB_RR_EN
  rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .upd      (state == DONE),
    .upd_port (win),
    .sel      (sel)
  );
`else
  assign sel = ~req[0];
`endif

  assign sel_oh  = sel ? 2'b10 : 2'b01;
  // Requester drives write data combinationally from word_idx, so pass it straight through.
  assign mem_din = (state == WR) ? req_wdata[win] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      win      <= 1'b0;
      base     <= '0;
      cnt      <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      wack     <= '0;
      done     <= '0;
      rdata    <= '0;
      word_idx <= '0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
    end else begin
      rvalid <= '0;
      wack   <= '0;
      done   <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            win      <= sel;
            base     <= req_addr[sel][31:OFFSET_W];
            gnt      <= sel_oh;
            word_idx <= '0;
            mem_addr <= {req_addr[sel][31:OFFSET_W], {IDX_W{1'b0}}, 2'b00};
            if (req_we[sel]) begin
              state   <= WR;
              mem_wen <= 1'b1;
              wack    <= sel_oh;
            end else begin
              state   <= RD_ISSUE;
              mem_ren <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          mem_ren  <= 1'b0;
          cnt      <= '0;
          word_idx <= mem_addr[OFFSET_W-1:2];
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          // The rvalid cycle doubles as the next issue (or DONE), so word_idx lags mem_addr here.
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            rdata  <= mem_dout;
            rvalid <= gnt;
            if (word_idx == LAST) begin
              state <= DONE;
              done  <= gnt;
              gnt   <= '0;
            end else begin
              state    <= RD_ISSUE;
              mem_ren  <= 1'b1;
              mem_addr <= {base, IDX_W'(word_idx + 1'b1), 2'b00};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (word_idx == LAST) begin
            state   <= DONE;
            mem_wen <= 1'b0;
            done    <= gnt;
            gnt     <= '0;
          end else begin
            word_idx <= word_idx + 1'b1;
            mem_addr <= {base, IDX_W'(word_idx + 1'b1), 2'b00};
            wack     <= gnt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
